// File: rtl/judge_pkg.sv
// Shared types and constants for the judge result generator and its channel voters.
package judge_pkg;
  localparam int JR_W           = 9;
  localparam int NUM_CH         = 8;
  localparam int BURST_LEN      = 15;
  localparam int JR_HEALTHY_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT,
    ST_GAP
  } judge_state_e;
endpackage

// File: rtl/jr_channel_vote.sv
// One channel's fault counter with a strict-majority vote against the valid-sample count.
module jr_channel_vote
  import judge_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic [7:0] i_valid_nxt,
  output logic       o_fault
);

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + {7'd0, i_inc};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= w_cnt_nxt;
  end

  // Vote on the post-increment counts so a sample on the final window cycle is included.
  assign o_fault = {w_cnt_nxt, 1'b0} > {1'b0, i_valid_nxt};

endmodule

// File: rtl/judge_result_generator.sv
// Windowed per-channel fault voter emitting bursts of 15 result words separated by idle gaps.
//   state   | meaning
//   IDLE    | disabled, counters clear
//   COLLECT | accumulating qualified samples for WINDOW cycles
//   EMIT    | result strobe cycle
//   GAP     | idle cycles after the 15th result of a burst
module judge_result_generator
  import judge_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int GAP    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable_i,
  input  logic              flag_valid_i,
  input  logic [NUM_CH-1:0] fault_flag_i,
  output logic [JR_W-1:0]   judge_result_o,
  output logic              judge_result_en_o,
  output logic              busy_o,
  output logic              burst_done_o
);

  localparam logic [7:0] WIN_LD     = 8'(WINDOW - 1);
  localparam logic [7:0] GAP_LD     = 8'(GAP - 1);
  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN);

  judge_state_e      r_state, w_state_nxt;
  logic [7:0]        r_timer;
  logic [7:0]        r_valid_cnt, w_valid_nxt;
  logic [3:0]        r_burst_cnt;
  logic [JR_W-1:0]   r_result, w_word;
  logic              r_en, r_burst_done;
  logic              w_collect, w_last, w_clr, w_burst_end;
  logic [NUM_CH-1:0] w_fault;

  assign w_collect   = enable_i && (r_state == ST_COLLECT);
  assign w_last      = w_collect && (r_timer == '0);
  assign w_clr       = !w_collect;
  assign w_valid_nxt = r_valid_cnt + {7'd0, flag_valid_i};
  assign w_burst_end = (r_state == ST_EMIT) && (r_burst_cnt == BURST_LAST);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_vote
      jr_channel_vote u_vote (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (w_clr),
        .i_inc      (flag_valid_i & fault_flag_i[g]),
        .i_valid_nxt(w_valid_nxt),
        .o_fault    (w_fault[g])
      );
    end
  endgenerate

  always_comb begin
    w_word                 = '0;
    w_word[NUM_CH-1:0]     = w_fault;
    w_word[JR_HEALTHY_BIT] = (w_valid_nxt != '0) && (w_fault == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_COLLECT;
        ST_COLLECT: if (r_timer == '0) w_state_nxt = ST_EMIT;
        ST_EMIT:    w_state_nxt = w_burst_end ? ST_GAP : ST_COLLECT;
        ST_GAP:     if (r_timer == '0) w_state_nxt = ST_COLLECT;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // One down-counter serves both the window and the gap; it loads on state entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                                    r_timer <= '0;
    else if (!enable_i)                                           r_timer <= '0;
    else if (w_state_nxt == ST_COLLECT && r_state != ST_COLLECT)  r_timer <= WIN_LD;
    else if (w_state_nxt == ST_GAP && r_state != ST_GAP)          r_timer <= GAP_LD;
    else if (r_timer != '0)                                       r_timer <= r_timer - 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid_cnt  <= '0;
      r_burst_cnt  <= '0;
      r_result     <= '0;
      r_en         <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_valid_cnt  <= w_clr ? '0 : w_valid_nxt;
      r_en         <= w_last;
      r_burst_done <= enable_i && w_burst_end;
      if (w_last) r_result <= w_word;
      if (!enable_i)        r_burst_cnt <= '0;
      else if (w_last)      r_burst_cnt <= r_burst_cnt + 4'd1;
      else if (w_burst_end) r_burst_cnt <= '0;
    end
  end

  assign judge_result_o    = r_result;
  assign judge_result_en_o = r_en;
  assign busy_o            = (r_state != ST_IDLE);
  assign burst_done_o      = r_burst_done;

endmodule

// File: tb/tb_judge_result_generator.sv
// Directed bench: a 15-entry vector table drives whole bursts, plus enable-drop and mid-window reset sequences.
module tb_judge_result_generator;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable_i = 1'b0;
  logic       flag_valid_i = 1'b0;
  logic [7:0] fault_flag_i = 8'h00;
  logic [8:0] judge_result_o;
  logic       judge_result_en_o, busy_o, burst_done_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] flags;
    int         n_valid;
    int         n_flag;
    bit         last_only;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[15];

  judge_result_generator #(.WINDOW(16), .GAP(4)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .enable_i         (enable_i),
    .flag_valid_i     (flag_valid_i),
    .fault_flag_i     (fault_flag_i),
    .judge_result_o   (judge_result_o),
    .judge_result_en_o(judge_result_en_o),
    .busy_o           (busy_o),
    .burst_done_o     (burst_done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered at the negedge of the first COLLECT cycle; returns at the negedge of the EMIT cycle.
  task automatic do_window(input vec_t v, input string tag);
    int en_seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (judge_result_en_o) en_seen++;
      if (v.last_only) begin
        flag_valid_i = (i == 15);
        fault_flag_i = (i == 15) ? v.flags : 8'h00;
      end else begin
        flag_valid_i = (i < v.n_valid);
        fault_flag_i = (i < v.n_flag) ? v.flags : 8'h00;
      end
    end
    @(negedge clk);
    chk({tag, " no-strobe-in-window"}, en_seen, 0);
    chk({tag, " strobe"}, judge_result_en_o, 1);
    chk({tag, " word"}, judge_result_o, v.exp);
    flag_valid_i = 1'b1;
    fault_flag_i = 8'hFF;
  endtask

  // Full 15-result burst followed by the gap; returns at the first COLLECT cycle of the next burst.
  task automatic run_burst(input string tag);
    for (int k = 0; k < 15; k++) begin
      do_window(tbl[k], $sformatf("%s r%0d", tag, k + 1));
      @(negedge clk);
      if (k < 14) begin
        chk($sformatf("%s r%0d done-low", tag, k + 1), burst_done_o, 0);
        chk($sformatf("%s r%0d strobe-one-cycle", tag, k + 1), judge_result_en_o, 0);
      end
    end
    chk({tag, " burst_done"}, burst_done_o, 1);
    chk({tag, " gap1 strobe"}, judge_result_en_o, 0);
    for (int j = 2; j <= 4; j++) begin
      @(negedge clk);
      chk($sformatf("%s gap%0d done", tag, j), burst_done_o, 0);
      chk($sformatf("%s gap%0d strobe", tag, j), judge_result_en_o, 0);
      chk($sformatf("%s gap%0d hold", tag, j), judge_result_o, tbl[14].exp);
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{8'h00, 16,  0, 1'b0, 9'h100};
    tbl[1]  = '{8'h04, 16,  9, 1'b0, 9'h004};
    tbl[2]  = '{8'h04, 16,  8, 1'b0, 9'h100};
    tbl[3]  = '{8'h42, 16, 12, 1'b0, 9'h042};
    tbl[4]  = '{8'hFF,  0, 16, 1'b0, 9'h000};
    tbl[5]  = '{8'h81,  4, 16, 1'b0, 9'h081};
    tbl[6]  = '{8'hFF, 16, 16, 1'b0, 9'h0FF};
    tbl[7]  = '{8'h10,  1,  1, 1'b0, 9'h010};
    tbl[8]  = '{8'h01,  3,  1, 1'b0, 9'h100};
    tbl[9]  = '{8'h20,  0,  0, 1'b1, 9'h020};
    tbl[10] = '{8'h00, 16,  0, 1'b0, 9'h100};
    tbl[11] = '{8'h3C, 16,  9, 1'b0, 9'h03C};
    tbl[12] = '{8'h80, 16,  8, 1'b0, 9'h100};
    tbl[13] = '{8'h02, 15,  8, 1'b0, 9'h002};
    tbl[14] = '{8'h55, 16, 16, 1'b0, 9'h055};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset word", judge_result_o, 9'h000);
    chk("reset strobe", judge_result_en_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset done", burst_done_o, 0);
    rstn = 1'b1;
    flag_valid_i = 1'b1;
    fault_flag_i = 8'hFF;
    @(negedge clk);
    chk("idle busy", busy_o, 0);
    enable_i = 1'b1;
    @(negedge clk);
    chk("collect busy", busy_o, 1);

    run_burst("b1");

    // Enable drop during the 7th window
    for (int k = 0; k < 6; k++) begin
      do_window(tbl[0], $sformatf("drop r%0d", k + 1));
      @(negedge clk);
      chk($sformatf("drop r%0d done-low", k + 1), burst_done_o, 0);
    end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      flag_valid_i = 1'b1;
      fault_flag_i = 8'h00;
      if (i == 15) enable_i = 1'b0;
    end
    @(negedge clk);
    chk("drop strobe", judge_result_en_o, 0);
    chk("drop busy", busy_o, 0);
    chk("drop word hold", judge_result_o, 9'h100);
    fault_flag_i = 8'hFF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("idle%0d strobe", j), judge_result_en_o, 0);
      chk($sformatf("idle%0d busy", j), busy_o, 0);
      chk($sformatf("idle%0d done", j), burst_done_o, 0);
    end
    enable_i = 1'b1;
    @(negedge clk);

    run_burst("b2");

    // Reset in the middle of a window
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      flag_valid_i = 1'b1;
      fault_flag_i = 8'h08;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst word", judge_result_o, 9'h000);
    chk("midrst strobe", judge_result_en_o, 0);
    chk("midrst busy", busy_o, 0);
    chk("midrst done", burst_done_o, 0);
    repeat (2) begin
      @(negedge clk);
      chk("in-reset strobe", judge_result_en_o, 0);
      chk("in-reset busy", busy_o, 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("post-reset busy", busy_o, 1);
    do_window('{8'h08, 16, 16, 1'b0, 9'h008}, "post-reset");
    @(negedge clk);
    chk("post-reset done-low", burst_done_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
